// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory port arbiter: port-select
// encodings, FSM state type and a select-to-one-hot helper.
package cpu_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] SEL_P0 = 2'b00;
  localparam logic [1:0] SEL_P1 = 2'b01;
  localparam logic [1:0] SEL_P2 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Select code to one-hot requester vector; the unused code 11 maps to zero.
  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [1:0] s);
    logic [NUM_REQ-1:0] oh;
    case (s)
      SEL_P0:  oh = 3'b001;
      SEL_P1:  oh = 3'b010;
      SEL_P2:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker: searches last+1, last+2,
// last+3 (mod 3) and returns the first asserted requester.
module rr_pick3
  import cpu_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] pick
);

  // Rotate the search start to just after the last-served requester.
  always_comb begin
    any  = |req;
    pick = SEL_P0;
    case (last)
      SEL_P0: begin
        if (req[1])      pick = SEL_P1;
        else if (req[2]) pick = SEL_P2;
        else             pick = SEL_P0;
      end
      SEL_P1: begin
        if (req[2])      pick = SEL_P2;
        else if (req[0]) pick = SEL_P0;
        else if (req[1]) pick = SEL_P1;
        else             pick = SEL_P0;
      end
      default: begin
        if (req[0])      pick = SEL_P0;
        else if (req[1]) pick = SEL_P1;
        else if (req[2]) pick = SEL_P2;
        else             pick = SEL_P0;
      end
    endcase
  end

endmodule

// File: rtl/word_mux3.sv
// Generic 3:1 word multiplexer driven by a 2-bit port select.
module word_mux3
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] y
);

  // Select the word; the unused code falls back to port 0.
  always_comb begin
    case (sel)
      SEL_P0:  y = d0;
      SEL_P1:  y = d1;
      SEL_P2:  y = d2;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among fetch, load/store and
// debug/DMA requesters, with request/done handshake and access timeout.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] addr2,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [WIDTH-1:0] wdata2,
  input  logic [2:0]       we,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [1:0]       sel,
  output logic [2:0]       gnt,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] rdata,
  output logic [2:0]       done,
  output logic [2:0]       err
);

  localparam int               TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TO_LAST   = TO_LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e             state_r,     state_nxt_s;
  logic [1:0]         sel_r,       sel_nxt_s;
  logic [1:0]         last_r,      last_nxt_s;
  logic [2:0]         gnt_r,       gnt_nxt_s;
  logic               valid_r,     valid_nxt_s;
  logic [2:0]         done_r,      done_nxt_s;
  logic [2:0]         err_r,       err_nxt_s;
  logic [WIDTH-1:0]   rdata_r,     rdata_nxt_s;
  logic [CNT_W-1:0]   cnt_r,       cnt_nxt_s;

  logic               any_s;
  logic [1:0]         pick_s;
  logic               timeout_hit_s;
  logic               we_sel_s;

  rr_pick3 u_pick (
    .req  (req),
    .last (last_r),
    .any  (any_s),
    .pick (pick_s)
  );

  word_mux3 #(.WIDTH(WIDTH)) u_addr_mux (
    .sel (sel_r),
    .d0  (addr0),
    .d1  (addr1),
    .d2  (addr2),
    .y   (mem_addr)
  );

  word_mux3 #(.WIDTH(WIDTH)) u_wdata_mux (
    .sel (sel_r),
    .d0  (wdata0),
    .d1  (wdata1),
    .d2  (wdata2),
    .y   (mem_wdata)
  );

  assign timeout_hit_s = (TIMEOUT != 0) && (cnt_r == TO_LAST);

  // Write-enable mux, gated so nothing is written while idle.
  always_comb begin
    case (sel_r)
      SEL_P0:  we_sel_s = we[0];
      SEL_P1:  we_sel_s = we[1];
      SEL_P2:  we_sel_s = we[2];
      default: we_sel_s = 1'b0;
    endcase
    mem_we = valid_r & we_sel_s;
  end

  // Next-state and next-output logic; done/err default low so they pulse once.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    last_nxt_s  = last_r;
    gnt_nxt_s   = gnt_r;
    valid_nxt_s = valid_r;
    done_nxt_s  = 3'b000;
    err_nxt_s   = 3'b000;
    rdata_nxt_s = rdata_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          sel_nxt_s   = pick_s;
          gnt_nxt_s   = sel_onehot(pick_s);
          valid_nxt_s = 1'b1;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rdata_nxt_s = mem_rdata;
          done_nxt_s  = sel_onehot(sel_r);
          last_nxt_s  = sel_r;
          gnt_nxt_s   = 3'b000;
          valid_nxt_s = 1'b0;
          state_nxt_s = IDLE;
        end else if (timeout_hit_s) begin
          err_nxt_s   = sel_onehot(sel_r);
          last_nxt_s  = sel_r;
          gnt_nxt_s   = 3'b000;
          valid_nxt_s = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = 3'b000;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      sel_r   <= SEL_P0;
      last_r  <= SEL_P2;
      gnt_r   <= 3'b000;
      valid_r <= 1'b0;
      done_r  <= 3'b000;
      err_r   <= 3'b000;
      rdata_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      sel_r   <= sel_nxt_s;
      last_r  <= last_nxt_s;
      gnt_r   <= gnt_nxt_s;
      valid_r <= valid_nxt_s;
      done_r  <= done_nxt_s;
      err_r   <= err_nxt_s;
      rdata_r <= rdata_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign sel       = sel_r;
  assign gnt       = gnt_r;
  assign mem_valid = valid_r;
  assign done      = done_r;
  assign err       = err_r;
  assign rdata     = rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (built with TIMEOUT = 4).
module tb_mem_port_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [2:0]       req;
  logic [WIDTH-1:0] addr0, addr1, addr2;
  logic [WIDTH-1:0] wdata0, wdata1, wdata2;
  logic [2:0]       we;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;
  logic [1:0]       sel;
  logic [2:0]       gnt;
  logic             mem_valid;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;
  logic [WIDTH-1:0] rdata;
  logic [2:0]       done;
  logic [2:0]       err;

  int n_checks;
  int n_pass;

  mem_port_arbiter #(.WIDTH(WIDTH), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr0     (addr0),
    .addr1     (addr1),
    .addr2     (addr2),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .wdata2    (wdata2),
    .we        (we),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .sel       (sel),
    .gnt       (gnt),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .rdata     (rdata),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    req       = 3'b000;
    addr0     = 32'h0000_0A00;
    addr1     = 32'h0000_1000;
    addr2     = 32'h0000_0040;
    wdata0    = 32'h0000_0000;
    wdata1    = 32'h0000_0000;
    wdata2    = 32'h1234_5678;
    we        = 3'b000;
    mem_ready = 1'b0;
    mem_rdata = 32'h0000_0000;
    tick();
    tick();
    rst = 1'b0;

    check_val("rst_sel",   {30'd0, sel}, 32'd0);
    check_val("rst_gnt",   {29'd0, gnt}, 32'd0);
    check_val("rst_valid", {31'd0, mem_valid}, 32'd0);
    check_val("rst_done",  {29'd0, done}, 32'd0);
    check_val("rst_err",   {29'd0, err}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_we",    {31'd0, mem_we}, 32'd0);

    // Single read from requester 1, memory answers on the third BUSY edge.
    req = 3'b010;
    tick();
    check_val("t1_gnt",   {29'd0, gnt}, 32'h2);
    check_val("t1_sel",   {30'd0, sel}, 32'h1);
    check_val("t1_valid", {31'd0, mem_valid}, 32'h1);
    check_val("t1_addr",  mem_addr, 32'h0000_1000);
    tick();
    tick();
    check_val("t1_nodone", {29'd0, done}, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    check_val("t1_done",  {29'd0, done}, 32'h2);
    check_val("t1_rdata", rdata, 32'hDEAD_BEEF);
    check_val("t1_gnt0",  {29'd0, gnt}, 32'h0);
    mem_ready = 1'b0;
    req = 3'b000;
    tick();
    check_val("t1_done1", {29'd0, done}, 32'h0);

    // Round robin from reset: order 0,1,2,0,1,2 with one idle cycle between.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 3'b111;
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0000;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val("rr_gnt", {29'd0, gnt}, 32'(1 << (k % 3)));
      check_val("rr_sel", {30'd0, sel}, 32'(k % 3));
      tick();
      check_val("rr_idle", {29'd0, gnt}, 32'h0);
      check_val("rr_done", {29'd0, done}, 32'(1 << (k % 3)));
    end
    req = 3'b000;
    mem_ready = 1'b0;
    tick();

    // Write from requester 2.
    req = 3'b100;
    we  = 3'b100;
    tick();
    check_val("wr_sel",   {30'd0, sel}, 32'h2);
    check_val("wr_we",    {31'd0, mem_we}, 32'h1);
    check_val("wr_addr",  mem_addr, 32'h0000_0040);
    check_val("wr_wdata", mem_wdata, 32'h1234_5678);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_0000;
    tick();
    check_val("wr_done",  {29'd0, done}, 32'h4);
    check_val("wr_we0",   {31'd0, mem_we}, 32'h0);
    check_val("wr_rdata", rdata, 32'hCAFE_0000);
    req = 3'b000;
    we  = 3'b000;
    mem_ready = 1'b0;
    tick();

    // Timeout on requester 0 with requester 1 pending.
    req = 3'b011;
    tick();
    check_val("to_gnt", {29'd0, gnt}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("to_noerr", {29'd0, err}, 32'h0);
      check_val("to_hold",  {29'd0, gnt}, 32'h1);
    end
    tick();
    check_val("to_err",    {29'd0, err}, 32'h1);
    check_val("to_nodone", {29'd0, done}, 32'h0);
    check_val("to_gnt0",   {29'd0, gnt}, 32'h0);
    check_val("to_valid",  {31'd0, mem_valid}, 32'h0);
    check_val("to_rdata",  rdata, 32'hCAFE_0000);
    req = 3'b010;
    tick();
    check_val("to_err1", {29'd0, err}, 32'h0);
    check_val("to_next", {29'd0, gnt}, 32'h2);

    // Ready arrives on the same edge the timeout would fire: done wins.
    for (int k = 0; k < 3; k++) begin
      tick();
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h55AA_55AA;
    tick();
    check_val("tie_done",  {29'd0, done}, 32'h2);
    check_val("tie_err",   {29'd0, err}, 32'h0);
    check_val("tie_rdata", rdata, 32'h55AA_55AA);
    req = 3'b000;
    mem_ready = 1'b0;
    tick();

    // Reset during the second BUSY cycle abandons the access silently.
    req = 3'b111;
    tick();
    check_val("mr_gnt", {29'd0, gnt}, 32'h4);
    tick();
    rst = 1'b1;
    mem_ready = 1'b1;
    tick();
    check_val("mr_gnt0",  {29'd0, gnt}, 32'h0);
    check_val("mr_valid", {31'd0, mem_valid}, 32'h0);
    check_val("mr_done",  {29'd0, done}, 32'h0);
    check_val("mr_err",   {29'd0, err}, 32'h0);
    check_val("mr_rdata", rdata, 32'h0);
    rst = 1'b0;
    mem_ready = 1'b0;
    tick();
    check_val("mr_first", {29'd0, gnt}, 32'h1);
    check_val("mr_sel",   {30'd0, sel}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between three requesters: 0 = instruction fetch, 1 = data load/store, 2 = debug/DMA.
- Uses round-robin arbitration with a request/done handshake.
- Drives the 2-bit port select for the address, write-data and write-enable 3:1 muxes. Encoding: 00 = port0, 01 = port1, 10 = port2. 11 is never produced.
- Sits between the CPU front-end/LSU and the unified memory wrapper.

Parameters:
- WIDTH, 32: address and data width.
- TIMEOUT, 255: maximum cycles to wait for mem_ready before aborting. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy TIMEOUT <= 2^CNT_W - 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  3  per-requester request. Held high until that requester's done or err.
- addr0, addr1, addr2  in  WIDTH each  per-requester address.
- wdata0, wdata1, wdata2  in  WIDTH each  per-requester write data.
- we  in  3  per-requester write enable.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_rdata  in  WIDTH  memory read data, valid when mem_ready = 1.
- sel  out  2  current port select (00/01/10).
- gnt  out  3  one-hot grant; zero when idle.
- mem_valid  out  1  access in progress toward memory.
- mem_addr  out  WIDTH  muxed address.
- mem_wdata  out  WIDTH  muxed write data.
- mem_we  out  1  muxed write enable, gated by mem_valid.
- rdata  out  WIDTH  registered read data from the last completed access.
- done  out  3  one-cycle completion pulse to the granted requester.
- err  out  3  one-cycle timeout pulse to the granted requester.

Behaviour:
- Reset (sync, rst = 1 at an edge) forces:
  - sel = 2'b00, gnt = 0, mem_valid = 0, done = 0, err = 0, rdata = 0, timeout counter = 0.
  - last-served pointer = 2, so requester 0 has first priority.
  - FSM to IDLE.
  - Reset mid-transaction abandons the access with no done or err pulse.
- FSM states: IDLE, BUSY, all outputs registered.
- IDLE:
  - If req != 0, pick the first asserted requester in the order last+1, last+2, last+3 (mod 3).
  - Register sel and gnt (one-hot), set mem_valid = 1, clear the counter, go to BUSY.
  - Latency: req sampled at edge N, so gnt and mem_valid are high after edge N.
- BUSY:
  - sel and gnt are held stable. mem_addr, mem_wdata and mem_we are combinationally muxed from the sel'd port inputs.
  - If mem_ready = 1:
    - rdata <= mem_rdata (for writes too).
    - done[sel] = 1 for one cycle.
    - last <= sel.
    - gnt, mem_valid <= 0.
    - Go to IDLE.
  - Else if TIMEOUT != 0 and the counter reaches TIMEOUT-1:
    - err[sel] = 1 for one cycle.
    - last <= sel, gnt and mem_valid <= 0.
    - Go to IDLE.
    - rdata is unchanged.
  - Else the counter increments; it saturates and never wraps.
- Dropping req while BUSY is ignored; the access completes normally.
- At least one IDLE cycle separates transactions, so back-to-back grants are spaced by 1 bubble.
- mem_ready while IDLE is ignored and produces no pulse.
- mem_ready and timeout in the same cycle: mem_ready wins, giving done, not err.
- sel keeps its last value while IDLE. Consumers qualify it with mem_valid.
- Muxed outputs while idle: mem_we = 0. mem_addr and mem_wdata follow the held sel.

Decomposition:
- Shared package (cpu_pkg) holds:
  - SEL_P0 = 2'b00, SEL_P1 = 2'b01, SEL_P2 = 2'b10.
  - FSM state typedef {IDLE, BUSY}.
  - NUM_REQ = 3.
- One sub-module, rr_pick3: combinational round-robin picker. Inputs: req[2:0], last[1:0]. Outputs: any, pick[1:0].
- The existing 3:1 word mux is instantiated twice: once for mem_addr, once for mem_wdata.

Test Plan:
- Reset then single request: rst for 2 cycles; req = 3'b010, addr1 = 0x0000_1000, we = 0; mem_ready high 3 cycles after grant with mem_rdata = 0xDEAD_BEEF -> sel = 01, gnt = 010, mem_addr = 0x0000_1000, done = 010 for exactly one cycle, rdata = 0xDEAD_BEEF.
- Round-robin fairness: req = 3'b111 held with mem_ready = 1 every BUSY cycle -> grant order 0, 1, 2, 0, 1, 2; each gnt lasts 1 cycle, separated by 1 idle cycle; sel never 11.
- Write path: req = 3'b100, addr2 = 0x40, wdata2 = 0x1234_5678, we = 3'b100 -> mem_we = 1, mem_wdata = 0x1234_5678 while BUSY; mem_we = 0 after done.
- Timeout: TIMEOUT = 4, req = 3'b001, mem_ready held 0 -> err = 001 pulses on the 4th BUSY cycle, no done, rdata unchanged, FSM returns to IDLE; a pending req = 3'b010 is then granted next.
- Simultaneous mem_ready and timeout expiry on the same cycle -> done pulses, err stays 0.
- Reset mid-BUSY: assert rst on the 2nd BUSY cycle -> next cycle gnt = 0, mem_valid = 0, no done or err; requester 0 is served first afterwards.
